// File: rtl/peak_detect.sv
// Peak detector for a filtered sample stream. Finds local maxima above a
// threshold, using a hysteresis margin to reject small ripples, and reports
// each peak's value and index together with a per-frame peak count.
module peak_detect #(
  parameter int unsigned DW    = 12,
  parameter int unsigned IDXW  = 11,
  parameter int unsigned MAXPK = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_act,
  input  logic            pkd_en,
  input  logic            vald_din,
  input  logic [DW-1:0]   data_in,
  input  logic            frame_end,
  input  logic [DW-1:0]   thresh,
  input  logic [DW-1:0]   hyst,
  output logic [DW-1:0]   peak_val,
  output logic [IDXW-1:0] peak_idx,
  output logic            peak_valid,
  output logic [3:0]      peak_cnt,
  output logic            done,
  output logic            overflow
);

  typedef enum logic [1:0] {StBelow, StTrack, StFall} state_e;

  localparam logic [3:0] MaxPkCnt = 4'(MAXPK);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [DW-1:0]   cand_val_q, cand_val_d;
  logic [IDXW-1:0] cand_idx_q, cand_idx_d;
  logic [DW-1:0]   trough_q, trough_d;
  logic [DW-1:0]   peak_val_q, peak_val_d;
  logic [IDXW-1:0] peak_idx_q, peak_idx_d;
  logic            peak_valid_q, peak_valid_d;
  logic [3:0]      peak_cnt_q, peak_cnt_d;
  logic            done_q, done_d;
  logic            overflow_q, overflow_d;

  // Comparisons are done one bit wider so differences never wrap.
  logic [DW:0] sample_x, thresh_x, cand_x, trough_x, heff_x;
  logic        accept;
  logic        emit;

  assign sample_x = {1'b0, data_in};
  assign thresh_x = {1'b0, thresh};
  assign cand_x   = {1'b0, cand_val_q};
  assign trough_x = {1'b0, trough_q};
  // A zero margin would let equal neighbours count as a fall; force at least 1.
  assign heff_x   = (hyst == '0) ? (DW+1)'(1) : {1'b0, hyst};
  assign accept   = vald_din & pkd_en & ~done_q;

  // Next-state: frame control, detection FSM, peak reporting and counting.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cand_val_d   = cand_val_q;
    cand_idx_d   = cand_idx_q;
    trough_d     = trough_q;
    peak_val_d   = peak_val_q;
    peak_idx_d   = peak_idx_q;
    peak_valid_d = 1'b0;
    peak_cnt_d   = peak_cnt_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    emit         = 1'b0;

    if (start_act) begin
      // Same-cycle sample is dropped; last reported peak is kept.
      state_d    = StBelow;
      idx_d      = '0;
      peak_cnt_d = '0;
      overflow_d = 1'b0;
      done_d     = 1'b0;
    end else if (accept) begin
      if (idx_q != {IDXW{1'b1}}) begin
        idx_d = idx_q + 1'b1;
      end

      unique case (state_q)
        StBelow: begin
          if (sample_x >= thresh_x) begin
            state_d    = StTrack;
            cand_val_d = data_in;
            cand_idx_d = idx_q;
          end
        end
        StTrack: begin
          // Strictly greater so a plateau reports its first sample.
          if (sample_x > cand_x) begin
            cand_val_d = data_in;
            cand_idx_d = idx_q;
          end else if ((cand_x - sample_x) >= heff_x) begin
            emit     = 1'b1;
            trough_d = data_in;
            state_d  = StFall;
          end
        end
        StFall: begin
          if (sample_x < thresh_x) begin
            state_d = StBelow;
          end else if (sample_x < trough_x) begin
            trough_d = data_in;
          end else if ((sample_x - trough_x) >= heff_x) begin
            state_d    = StTrack;
            cand_val_d = data_in;
            cand_idx_d = idx_q;
          end
        end
        default: state_d = StBelow;
      endcase

      if (emit) begin
        peak_valid_d = 1'b1;
        peak_val_d   = cand_val_q;
        peak_idx_d   = cand_idx_q;
        if (peak_cnt_q == MaxPkCnt) begin
          overflow_d = 1'b1;
        end else begin
          peak_cnt_d = peak_cnt_q + 1'b1;
        end
      end

      // Last sample still counts, but an unfinished candidate is dropped.
      if (frame_end) begin
        done_d  = 1'b1;
        state_d = StBelow;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StBelow;
      idx_q        <= '0;
      cand_val_q   <= '0;
      cand_idx_q   <= '0;
      trough_q     <= '0;
      peak_val_q   <= '0;
      peak_idx_q   <= '0;
      peak_valid_q <= 1'b0;
      peak_cnt_q   <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cand_val_q   <= cand_val_d;
      cand_idx_q   <= cand_idx_d;
      trough_q     <= trough_d;
      peak_val_q   <= peak_val_d;
      peak_idx_q   <= peak_idx_d;
      peak_valid_q <= peak_valid_d;
      peak_cnt_q   <= peak_cnt_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign peak_val   = peak_val_q;
  assign peak_idx   = peak_idx_q;
  assign peak_valid = peak_valid_q;
  assign peak_cnt   = peak_cnt_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule
